// File: rtl/lau_pkg.sv
// Shared type definitions for the arithmetic unit library.
//   speed_e : selects the per-chunk carry logic (SLOW = ripple, FAST = parallel-prefix).
package lau_pkg;

  typedef enum logic {
    SLOW = 1'b0,
    FAST = 1'b1
  } speed_e;

endpackage

// File: rtl/add_pipe.sv
// Pipelined adder/subtractor: a width-bit add is split into `stages` chunks,
// one chunk per cycle, with the inter-chunk carry registered between stages.
// Ports:
//   clk_i, rst_ni             : clock, asynchronous active-low reset
//   clear_i                   : synchronous flush of every in-flight beat
//   in_valid_i / in_ready_o   : operand handshake (in_ready_o is combinational)
//   A_i, B_i, Ci_i, sub_i     : operands, carry-in (ignored on subtract), op select
//   out_valid_o / out_ready_i : result handshake
//   S_o, Co_o, V_o            : registered sum, carry-out (inverted borrow), signed overflow
module add_pipe #(
  parameter int unsigned     width  = 32,
  parameter int unsigned     stages = 4,
  parameter lau_pkg::speed_e speed  = lau_pkg::FAST
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [width-1:0] A_i,
  input  logic [width-1:0] B_i,
  input  logic             Ci_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [width-1:0] S_o,
  output logic             Co_o,
  output logic             V_o
);

  localparam int unsigned cw = width / stages;

  // One beat travelling down the pipe: operands keep their not-yet-used upper
  // chunks, the sum accumulates finished lower chunks, c is the carry into the
  // chunk handled by the stage that receives the beat.
  typedef struct packed {
    logic             v;
    logic             c;
    logic [width-1:0] a;
    logic [width-1:0] b;
    logic [width-1:0] s;
  } beat_t;

  // Chunk adder; returns {carry out, carry into chunk MSB, chunk sum}.
  function automatic logic [cw+1:0] chunk_add(input logic [cw-1:0] x,
                                               input logic [cw-1:0] y,
                                               input logic          cin);
    logic [cw-1:0] p;
    logic [cw-1:0] g;
    logic [cw-1:0] gp;
    logic [cw-1:0] pp;
    logic [cw:0]   c;
    p    = x ^ y;
    g    = x & y;
    gp   = g;
    pp   = p;
    c    = '0;
    c[0] = cin;
    if (speed == lau_pkg::SLOW) begin
      for (int i = 0; i < int'(cw); i++) c[i+1] = g[i] | (p[i] & c[i]);
    end else begin
      // Kogge-Stone prefix; descending i reads the previous level at i-d.
      for (int d = 1; d < int'(cw); d = d * 2) begin
        for (int i = int'(cw) - 1; i >= d; i--) begin
          gp[i] = gp[i] | (pp[i] & gp[i-d]);
          pp[i] = pp[i] & pp[i-d];
        end
      end
      for (int i = 0; i < int'(cw); i++) c[i+1] = gp[i] | (pp[i] & cin);
    end
    return {c[cw], c[cw-1], p ^ c[cw-1:0]};
  endfunction

  logic             adv;
  logic             accept;
  beat_t            head;
  beat_t            stage_in [stages];
  logic             last_v;
  logic             last_c;
  logic             last_ovf;
  logic [width-1:0] last_s;

  // Whole pipe moves together whenever the output slot is free or draining.
  assign adv        = ~out_valid_o | out_ready_i;
  assign in_ready_o = adv & ~clear_i;
  assign accept     = in_valid_i & in_ready_o;

  // Subtraction is A + ~B + 1; the external carry-in is ignored then.
  always_comb begin
    head   = '0;
    head.v = accept;
    head.c = sub_i | Ci_i;
    head.a = A_i;
    head.b = sub_i ? ~B_i : B_i;
  end

  for (genvar k = 0; k < int'(stages); k++) begin : g_stage
    logic [cw+1:0] res;

    if (k == 0) begin : g_head
      assign stage_in[k] = head;
    end

    assign res = chunk_add(stage_in[k].a[k*cw +: cw], stage_in[k].b[k*cw +: cw], stage_in[k].c);

    if (k < int'(stages) - 1) begin : g_reg
      beat_t nxt;
      beat_t q;

      // Insert this stage's sum chunk and forward its carry.
      always_comb begin
        nxt                 = stage_in[k];
        nxt.c               = res[cw+1];
        nxt.s[k*cw +: cw]   = res[cw-1:0];
      end

      // Stage register; clear drops the valid bit, data may stay stale.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          q <= '0;
        end else begin
          if (adv) q <= nxt;
          if (clear_i) q.v <= 1'b0;
        end
      end

      assign stage_in[k+1] = q;
    end else begin : g_last
      // Final chunk completes the word; overflow is carry-in xor carry-out of the MSB.
      always_comb begin
        last_s              = stage_in[k].s;
        last_s[k*cw +: cw]  = res[cw-1:0];
      end
      assign last_v   = stage_in[k].v;
      assign last_c   = res[cw+1];
      assign last_ovf = res[cw] ^ res[cw+1];
    end
  end

  // Output register; holds steady while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      S_o         <= '0;
      Co_o        <= 1'b0;
      V_o         <= 1'b0;
    end else begin
      if (adv) begin
        out_valid_o <= last_v;
        S_o         <= last_s;
        Co_o        <= last_c;
        V_o         <= last_ovf;
      end
      if (clear_i) out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_pipe.sv
// Directed bench for add_pipe: 32-bit/4-stage pair (FAST and SLOW carry logic)
// driven in lockstep, plus a width-16 sweep over stages {1,2,8} x {SLOW,FAST}.
module tb_add_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic        iv = 1'b0;
  logic        ordy = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ci = 1'b0;
  logic        sub = 1'b0;

  logic        irdy, ov, co, v;
  logic [31:0] s;
  logic        irdy2, ov2, co2, v2;
  logic [31:0] s2;

  logic        sw_iv = 1'b0;
  logic        sw_clr = 1'b0;
  logic        sw_ordy = 1'b1;
  logic [15:0] sw_a = 16'h7FFF;
  logic [15:0] sw_b = 16'h0001;
  logic        sw_ci = 1'b0;
  logic        sw_sub = 1'b0;
  logic        sw_rdy [6];
  logic        sw_ov  [6];
  logic [15:0] sw_s   [6];
  logic        sw_co  [6];
  logic        sw_v   [6];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  add_pipe #(.width(32), .stages(4), .speed(lau_pkg::FAST)) u_fast (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .in_valid_i(iv), .in_ready_o(irdy),
    .A_i(a), .B_i(b), .Ci_i(ci), .sub_i(sub), .out_valid_o(ov), .out_ready_i(ordy),
    .S_o(s), .Co_o(co), .V_o(v)
  );

  add_pipe #(.width(32), .stages(4), .speed(lau_pkg::SLOW)) u_slow (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .in_valid_i(iv), .in_ready_o(irdy2),
    .A_i(a), .B_i(b), .Ci_i(ci), .sub_i(sub), .out_valid_o(ov2), .out_ready_i(ordy),
    .S_o(s2), .Co_o(co2), .V_o(v2)
  );

  function automatic int sw_stages(input int i);
    return (i % 3 == 0) ? 1 : ((i % 3 == 1) ? 2 : 8);
  endfunction

  for (genvar i = 0; i < 6; i++) begin : g_sw
    localparam int unsigned st = (i % 3 == 0) ? 1 : ((i % 3 == 1) ? 2 : 8);
    localparam lau_pkg::speed_e sp = (i < 3) ? lau_pkg::SLOW : lau_pkg::FAST;
    add_pipe #(.width(16), .stages(st), .speed(sp)) u_sw (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(sw_clr), .in_valid_i(sw_iv), .in_ready_o(sw_rdy[i]),
      .A_i(sw_a), .B_i(sw_b), .Ci_i(sw_ci), .sub_i(sw_sub), .out_valid_o(sw_ov[i]),
      .out_ready_i(sw_ordy), .S_o(sw_s[i]), .Co_o(sw_co[i]), .V_o(sw_v[i])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result {V, Co, S}: signed overflow when both effective operands
  // share a sign that the result does not.
  function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mci, input logic msub);
    logic [31:0] be;
    logic        cin;
    logic [32:0] t;
    logic        ovf;
    be  = msub ? ~mb : mb;
    cin = msub ? 1'b1 : mci;
    t   = {1'b0, ma} + {1'b0, be} + 33'(cin);
    ovf = (ma[31] == be[31]) && (t[31] != ma[31]);
    return {ovf, t[32], t[31:0]};
  endfunction

  logic [33:0] q [$];
  logic [33:0] e;
  logic [31:0] pa, pb;
  logic        pci, psub;
  bit          have = 0;
  int          cyc = 0;
  int          got = 0;
  int          t_first = 0;
  int          t_last = 0;
  int          lat = 0;
  int          sent = 0;
  int          sw_lat [6];
  logic [15:0] sw_gs  [6];
  logic        sw_gco [6];
  logic        sw_gv  [6];

  task automatic next_beat();
    pa   = $urandom;
    pb   = $urandom;
    pci  = 1'($urandom_range(0, 1));
    psub = 1'($urandom_range(0, 1));
    have = 1;
  endtask

  // One clock of streaming traffic; entered and left at posedge+1.
  task automatic step(input bit o_rdy);
    ordy = o_rdy;
    iv   = have;
    if (have) begin a = pa; b = pb; ci = pci; sub = psub; end
    #1;
    chk("in_ready", irdy, !ov || o_rdy);
    if (!o_rdy) chk("hold_valid", ov, 1'b1);
    if (ov) begin
      if (q.size() == 0) begin
        chk("spurious_valid", ov, 1'b0);
      end else begin
        e = q[0];
        chk("stream_S", s, e[31:0]);
        chk("stream_Co", co, e[32]);
        chk("stream_V", v, e[33]);
        chk("slow_valid", ov2, 1'b1);
        chk("slow_S", s2, e[31:0]);
        chk("slow_CoV", {co2, v2}, {e[32], e[33]});
        if (o_rdy) begin
          void'(q.pop_front());
          if (got == 0) t_first = cyc;
          t_last = cyc;
          got++;
        end
      end
    end
    if (have && (!ov || o_rdy)) begin
      q.push_back(model(pa, pb, pci, psub));
      have = 0;
    end
    @(posedge clk);
    #1;
    iv = 0;
    cyc++;
  endtask

  // Single beat into an idle pipe; measures accept-to-valid latency in edges.
  task automatic single(input string tag, input logic [31:0] ta, input logic [31:0] tb2,
                        input logic tci, input logic tsub, input logic [31:0] es,
                        input logic eco, input logic ev);
    a = ta; b = tb2; ci = tci; sub = tsub; iv = 1; ordy = 1;
    #1;
    chk({tag, "_in_ready"}, irdy, 1'b1);
    @(posedge clk);
    #1;
    iv  = 0;
    lat = 1;
    while (!ov && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_S"}, s, es);
    chk({tag, "_Co"}, co, eco);
    chk({tag, "_V"}, v, ev);
    chk({tag, "_slow_S"}, s2, es);
    chk({tag, "_slow_CoV"}, {ov2, co2, v2}, {1'b1, eco, ev});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_out_valid", ov, 1'b0);
    chk("rst_S", s, 32'h0);
    chk("rst_CoV", {co, v}, 2'b00);
    chk("rst_in_ready", irdy, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed add/subtract vectors
    single("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    single("add_cin", 32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
    single("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    single("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    @(posedge clk);
    #1;

    // Back-to-back random stream
    q.delete();
    got = 0;
    for (int i = 0; i < 100; i++) begin
      next_beat();
      step(1'b1);
    end
    for (int n = 0; n < 10 && q.size() > 0; n++) step(1'b1);
    chk("stream_count", got, 100);
    chk("stream_rate", t_last - t_first, 99);
    chk("stream_drained", q.size(), 0);

    // Backpressure for 5 cycles mid-stream
    got  = 0;
    sent = 0;
    for (int j = 0; j < 60 && (sent < 20 || have || q.size() > 0); j++) begin
      if (!have && sent < 20) begin
        next_beat();
        sent++;
      end
      step(!(j >= 8 && j < 13));
    end
    chk("bp_count", got, 20);
    chk("bp_drained", q.size(), 0);

    // Flush with three beats in flight; an offered beat is refused during clear
    for (int i = 0; i < 3; i++) begin
      next_beat();
      step(1'b1);
    end
    clr  = 1'b1;
    iv   = 1'b1;
    ordy = 1'b1;
    #1;
    chk("clear_in_ready", irdy, 1'b0);
    chk("clear_slow_in_ready", irdy2, 1'b0);
    @(posedge clk);
    #1;
    clr  = 1'b0;
    iv   = 1'b0;
    have = 0;
    q.delete();
    for (int n = 0; n < 6; n++) begin
      chk("flush_no_valid", {ov, ov2}, 2'b00);
      @(posedge clk);
      #1;
    end
    single("post_clear", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Parameter sweep at width 16
    for (int i = 0; i < 6; i++) begin
      sw_lat[i] = 0;
      chk("sweep_in_ready", sw_rdy[i], 1'b1);
    end
    sw_iv = 1'b1;
    @(posedge clk);
    #1;
    sw_iv = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      for (int i = 0; i < 6; i++) begin
        if (sw_ov[i] && sw_lat[i] == 0) begin
          sw_lat[i] = n;
          sw_gs[i]  = sw_s[i];
          sw_gco[i] = sw_co[i];
          sw_gv[i]  = sw_v[i];
        end
      end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("sweep%0d_latency", i), sw_lat[i], sw_stages(i));
      chk($sformatf("sweep%0d_S", i), sw_gs[i], 16'h8000);
      chk($sformatf("sweep%0d_V", i), sw_gv[i], 1'b1);
      chk($sformatf("sweep%0d_Co", i), sw_gco[i], 1'b0);
    end

    // Asynchronous reset mid-stream
    q.delete();
    got = 0;
    for (int i = 0; i < 6; i++) begin
      next_beat();
      step(1'b1);
    end
    chk("pre_reset_valid", ov, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {ov, ov2}, 2'b00);
    chk("async_rst_S", s, 32'h0);
    chk("async_rst_CoV", {co, v}, 2'b00);
    have = 0;
    iv   = 1'b0;
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_idle", ov, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
